trace_capture: RTL and testbench

- Synthesizable successor to the simulation-only reg/mem trace dumping used by the top-level bench.
- Captures processor register-writeback and data-memory events on-chip, deduplicates and filters them, and buffers them in a FIFO.
- Serializes each record as bytes over a valid/ready byte stream; the stream feeds the SPART transmit path so traces can be pulled from silicon.
- Sits beside the processor in the top level, tapping the MW-stage writeback and CPU memory bus.

---
 rtl/trace_pkg.sv | 47 ++++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/trace_capture.sv | 249 ++++++++++++++++++++++++
 tb/tb_trace_capture.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared record-format constants, header layout and state encodings for trace_capture.
package trace_pkg;

   // Header tag values (bits [7:6] of the first record byte)
   localparam logic [1:0] TAG_REG   = 2'b00;
   localparam logic [1:0] TAG_STORE = 2'b01;
   localparam logic [1:0] TAG_LOAD  = 2'b10;
   localparam logic [1:0] TAG_RSVD  = 2'b11;

   // Header bit positions
   localparam int unsigned HDR_TAG_HI  = 7;
   localparam int unsigned HDR_TAG_LO  = 6;
   localparam int unsigned HDR_ZERO    = 5;
   localparam int unsigned HDR_OP_HI   = 4;
   localparam int unsigned HDR_OP_LO   = 0;
   localparam int unsigned HDR_TAG_W   = HDR_TAG_HI - HDR_TAG_LO + 1;
   localparam int unsigned HDR_ZERO_W  = HDR_TAG_LO - HDR_ZERO;
   localparam int unsigned HDR_OP_W    = HDR_OP_HI - HDR_OP_LO + 1;

   // First byte of every record
   typedef struct packed {
      logic [HDR_TAG_W-1:0]  tag;
      logic [HDR_ZERO_W-1:0] zero;
      logic [HDR_OP_W-1:0]   op;
   } rec_hdr_t;

   // Byte serializer states
   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_t;

   // Load slot states: data arrives one cycle after the address phase
   typedef enum logic [1:0] {
      LD_EMPTY = 2'b00,
      LD_WAIT  = 2'b01,
      LD_READY = 2'b10
   } ld_state_t;

   // Bytes per record: header plus PC, address and data fields
   function automatic int unsigned rec_bytes(input int unsigned pc_w,
                                             input int unsigned addr_w,
                                             input int unsigned data_w);
      return 1 + (pc_w + addr_w + data_w) / 8;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read; accepts a push while full if a pop happens the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   // Storage array; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/trace_capture.sv
// On-chip trace capture: filters register-writeback and memory events into records and streams them as bytes.
module trace_capture
   import trace_pkg::*;
#(
   parameter int unsigned      PC_W      = 24,
   parameter int unsigned      ADDR_W    = 24,
   parameter int unsigned      DATA_W    = 24,
   parameter int unsigned      REG_SEL_W = 4,
   parameter int unsigned      OP_W      = 5,
   parameter int unsigned      DEPTH     = 16,
   parameter logic [OP_W-1:0]  SKIP_OP   = OP_W'(5'b00001)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trace_en,
   input  logic                     reg_we,
   input  logic [PC_W-1:0]          reg_pc,
   input  logic [REG_SEL_W-1:0]     reg_sel,
   input  logic [DATA_W-1:0]        reg_data,
   input  logic [OP_W-1:0]          reg_op,
   input  logic                     mem_valid,
   input  logic                     mem_is_load,
   input  logic [PC_W-1:0]          mem_pc,
   input  logic [ADDR_W-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic [OP_W-1:0]          mem_op,
   output logic                     tx_valid,
   output logic [7:0]               tx_data,
   input  logic                     tx_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [15:0]              drop_cnt,
   output logic                     busy
);

   localparam int unsigned      NB       = rec_bytes(PC_W, ADDR_W, DATA_W);
   localparam int unsigned      REC_W    = 8 * NB;
   localparam int unsigned      IDX_W    = $clog2(NB);
   localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

   // Pending slots
   logic [PC_W-1:0]  last_reg_pc;
   logic             reg_pend, reg_pend_d;
   logic [REC_W-1:0] reg_rec, reg_rec_d;
   logic             st_pend, st_pend_d;
   logic [REC_W-1:0] st_rec, st_rec_d;
   ld_state_t        ld_state, ld_state_d;
   logic [REC_W-1:0] ld_rec, ld_rec_d;

   // Event qualification and drops
   rec_hdr_t         reg_hdr, st_hdr, ld_hdr;
   logic             reg_ev, st_ev, ld_ev;
   logic             reg_drop, st_drop, ld_drop;
   logic [1:0]       drop_inc;
   logic [16:0]      drop_sum;
   logic [15:0]      drop_cnt_d;

   // Arbiter / FIFO
   logic             push_ok;
   logic             gnt_ld, gnt_st, gnt_reg;
   logic [REC_W-1:0] push_rec;
   logic             fifo_push, fifo_pop;
   logic             fifo_full, fifo_empty;
   logic [REC_W-1:0] fifo_rdata;
   logic [CNT_W-1:0] fifo_cnt_d;

   // Serializer
   ser_state_t       ser_state, ser_state_d;
   logic [REC_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0] idx, idx_d;
   logic             busy_d;

   assign reg_hdr = '{tag: TAG_REG,   zero: '0, op: HDR_OP_W'(reg_op)};
   assign st_hdr  = '{tag: TAG_STORE, zero: '0, op: HDR_OP_W'(mem_op)};
   assign ld_hdr  = '{tag: TAG_LOAD,  zero: '0, op: HDR_OP_W'(mem_op)};

   assign reg_ev = trace_en && reg_we && (reg_pc != last_reg_pc);
   assign st_ev  = trace_en && mem_valid && !mem_is_load && (mem_op != SKIP_OP);
   assign ld_ev  = trace_en && mem_valid &&  mem_is_load && (mem_op != SKIP_OP);

   // A slot frees only when the arbiter pushes it this cycle
   assign reg_drop = reg_ev && reg_pend && !gnt_reg;
   assign st_drop  = st_ev && st_pend && !gnt_st;
   assign ld_drop  = ld_ev && ((ld_state == LD_WAIT) || ((ld_state == LD_READY) && !gnt_ld));

   assign drop_inc   = 2'(reg_drop) + 2'(st_drop) + 2'(ld_drop);
   assign drop_sum   = {1'b0, drop_cnt} + 17'(drop_inc);
   assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

   // Full FIFO still accepts when the serializer drains an entry this cycle
   assign push_ok   = !fifo_full || fifo_pop;
   assign fifo_push = gnt_ld || gnt_st || gnt_reg;

   // Fixed-priority arbiter: completed load, then store, then register
   always_comb begin
      gnt_ld   = 1'b0;
      gnt_st   = 1'b0;
      gnt_reg  = 1'b0;
      push_rec = '0;
      if (push_ok) begin
         if (ld_state == LD_READY) begin
            gnt_ld   = 1'b1;
            push_rec = ld_rec;
         end else if (st_pend) begin
            gnt_st   = 1'b1;
            push_rec = st_rec;
         end else if (reg_pend) begin
            gnt_reg  = 1'b1;
            push_rec = reg_rec;
         end
      end
   end

   // Slot next-state: release on grant, then capture any accepted new event
   always_comb begin
      reg_pend_d = reg_pend;
      reg_rec_d  = reg_rec;
      st_pend_d  = st_pend;
      st_rec_d   = st_rec;
      ld_state_d = ld_state;
      ld_rec_d   = ld_rec;

      if (gnt_reg) begin
         reg_pend_d = 1'b0;
      end
      if (reg_ev && !reg_drop) begin
         reg_pend_d = 1'b1;
         reg_rec_d  = {reg_hdr, reg_pc, ADDR_W'(reg_sel), reg_data};
      end

      if (gnt_st) begin
         st_pend_d = 1'b0;
      end
      if (st_ev && !st_drop) begin
         st_pend_d = 1'b1;
         st_rec_d  = {st_hdr, mem_pc, mem_addr, mem_wdata};
      end

      case (ld_state)
         LD_WAIT: begin
            ld_state_d               = LD_READY;
            ld_rec_d[DATA_W-1:0]     = mem_rdata;
         end
         LD_READY: begin
            if (gnt_ld) begin
               ld_state_d = LD_EMPTY;
            end
         end
         default: ;
      endcase
      if (ld_ev && !ld_drop) begin
         ld_state_d = LD_WAIT;
         ld_rec_d   = {ld_hdr, mem_pc, mem_addr, {DATA_W{1'b0}}};
      end
   end

   // Serializer next-state: pop on entry and back-to-back at end of record
   always_comb begin
      ser_state_d = ser_state;
      shift_d     = shift_q;
      idx_d       = idx;
      fifo_pop    = 1'b0;
      case (ser_state)
         SER_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               shift_d     = fifo_rdata;
               idx_d       = '0;
               ser_state_d = SER_SEND;
            end
         end
         SER_SEND: begin
            if (tx_ready) begin
               if (idx == LAST_IDX) begin
                  idx_d = '0;
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     shift_d  = fifo_rdata;
                  end else begin
                     shift_d     = '0;
                     ser_state_d = SER_IDLE;
                  end
               end else begin
                  idx_d   = idx + IDX_W'(1);
                  shift_d = {shift_q[REC_W-9:0], 8'h00};
               end
            end
         end
         default: ser_state_d = SER_IDLE;
      endcase
   end

   assign fifo_cnt_d = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
   assign busy_d     = reg_pend_d || st_pend_d || (ld_state_d != LD_EMPTY) ||
                       (fifo_cnt_d != '0) || (ser_state_d == SER_SEND);

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         last_reg_pc <= '1;
         reg_pend    <= 1'b0;
         reg_rec     <= '0;
         st_pend     <= 1'b0;
         st_rec      <= '0;
         ld_state    <= LD_EMPTY;
         ld_rec      <= '0;
         drop_cnt    <= '0;
         ser_state   <= SER_IDLE;
         shift_q     <= '0;
         idx         <= '0;
         busy        <= 1'b0;
      end else begin
         if (reg_we) begin
            last_reg_pc <= reg_pc;
         end
         reg_pend  <= reg_pend_d;
         reg_rec   <= reg_rec_d;
         st_pend   <= st_pend_d;
         st_rec    <= st_rec_d;
         ld_state  <= ld_state_d;
         ld_rec    <= ld_rec_d;
         drop_cnt  <= drop_cnt_d;
         ser_state <= ser_state_d;
         shift_q   <= shift_d;
         idx       <= idx_d;
         busy      <= busy_d;
      end
   end

   assign tx_valid = (ser_state == SER_SEND);
   assign tx_data  = shift_q[REC_W-1 -: 8];

   sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (push_rec),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_trace_capture.sv
// Randomized and directed bench for trace_capture with a transaction-level model and byte scoreboard.
module tb_trace_capture;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned NB    = 10;
   localparam logic [4:0]  SKIP  = 5'b00001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trace_en = 1'b0;
   logic        reg_we = 1'b0;
   logic [23:0] reg_pc = '0;
   logic [3:0]  reg_sel = '0;
   logic [23:0] reg_data = '0;
   logic [4:0]  reg_op = '0;
   logic        mem_valid = 1'b0;
   logic        mem_is_load = 1'b0;
   logic [23:0] mem_pc = '0;
   logic [23:0] mem_addr = '0;
   logic [23:0] mem_wdata = '0;
   logic [23:0] mem_rdata = '0;
   logic [4:0]  mem_op = '0;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic [4:0]  fifo_count;
   logic [15:0] drop_cnt;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   trace_capture dut (
      .clk(clk), .rst(rst), .trace_en(trace_en),
      .reg_we(reg_we), .reg_pc(reg_pc), .reg_sel(reg_sel), .reg_data(reg_data), .reg_op(reg_op),
      .mem_valid(mem_valid), .mem_is_load(mem_is_load), .mem_pc(mem_pc), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_op(mem_op),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .fifo_count(fifo_count), .drop_cnt(drop_cnt), .busy(busy)
   );

   // Reference model: one-deep slots, a record count for the FIFO, bytes left in the serializer
   bit          m_rg_v = 0, m_st_v = 0, m_ld_v = 0, m_ld_wait = 0;
   logic [79:0] m_rg_rec, m_st_rec, m_ld_rec;
   int          m_fifo_n = 0;
   int          m_ser_left = 0;
   int          m_drop = 0;
   logic [23:0] m_last_pc = '1;
   logic [7:0]  exp_q[$];
   logic [7:0]  rx_log[$];

   task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   function automatic logic [79:0] mk(input logic [1:0] tag, input logic [4:0] op,
                                      input logic [23:0] pc, input logic [23:0] addr,
                                      input logic [23:0] data);
      return {tag, 1'b0, op, pc, addr, data};
   endfunction

   function automatic bit model_busy();
      return m_rg_v || m_st_v || m_ld_v || (m_fifo_n > 0) || (m_ser_left > 0);
   endfunction

   task automatic model_push(input logic [79:0] r);
      for (int i = 0; i < 10; i++) exp_q.push_back(r[79-8*i -: 8]);
      m_fifo_n++;
   endtask

   // Advance the model by one clock using the inputs that will be sampled at the next edge
   task automatic model_step();
      bit pop, push_ok;
      int drops;
      if (rst) begin
         m_rg_v = 0; m_st_v = 0; m_ld_v = 0; m_ld_wait = 0;
         m_fifo_n = 0; m_ser_left = 0; m_drop = 0; m_last_pc = '1;
         exp_q.delete();
         return;
      end
      pop = 0;
      if (m_ser_left == 0) pop = (m_fifo_n > 0);
      else if (tx_ready) begin
         m_ser_left--;
         if (m_ser_left == 0 && m_fifo_n > 0) pop = 1;
      end
      push_ok = (m_fifo_n < DEPTH) || pop;
      if (pop) begin m_fifo_n--; m_ser_left = NB; end
      if (push_ok) begin
         if (m_ld_v && !m_ld_wait) begin model_push(m_ld_rec); m_ld_v = 0; end
         else if (m_st_v) begin model_push(m_st_rec); m_st_v = 0; end
         else if (m_rg_v) begin model_push(m_rg_rec); m_rg_v = 0; end
      end
      drops = 0;
      if (trace_en && reg_we && reg_pc != m_last_pc) begin
         if (m_rg_v) drops++;
         else begin m_rg_v = 1; m_rg_rec = mk(2'b00, reg_op, reg_pc, {20'h0, reg_sel}, reg_data); end
      end
      if (reg_we) m_last_pc = reg_pc;
      if (trace_en && mem_valid && !mem_is_load && mem_op != SKIP) begin
         if (m_st_v) drops++;
         else begin m_st_v = 1; m_st_rec = mk(2'b01, mem_op, mem_pc, mem_addr, mem_wdata); end
      end
      if (m_ld_v && m_ld_wait) begin
         if (trace_en && mem_valid && mem_is_load && mem_op != SKIP) drops++;
         m_ld_rec[23:0] = mem_rdata;
         m_ld_wait = 0;
      end else if (m_ld_v) begin
         if (trace_en && mem_valid && mem_is_load && mem_op != SKIP) drops++;
      end else if (trace_en && mem_valid && mem_is_load && mem_op != SKIP) begin
         m_ld_v = 1; m_ld_wait = 1;
         m_ld_rec = mk(2'b10, mem_op, mem_pc, mem_addr, 24'h0);
      end
      m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
   endtask

   // Monitor: score every accepted byte and check stall stability
   logic [7:0] prev_data;
   bit         prev_stall = 0;
   always @(negedge clk) begin
      if (rst) prev_stall = 0;
      else begin
         if (prev_stall) begin
            chk("stall_valid", tx_valid, 1'b1);
            chk("stall_data", tx_data, prev_data);
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL tx_byte: got %0h, expected no byte (t=%0t)", tx_data, $time);
            end else chk("tx_byte", tx_data, exp_q.pop_front());
            rx_log.push_back(tx_data);
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   task automatic step();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      chk("fifo_count", fifo_count, m_fifo_n);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("busy", busy, model_busy());
      chk("tx_valid", tx_valid, m_ser_left > 0);
   endtask

   task automatic idle_inputs();
      reg_we = 0; mem_valid = 0; mem_is_load = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; step(); rst = 0;
      rx_log.delete();
   endtask

   task automatic drain(input int budget);
      int k = 0;
      idle_inputs();
      while ((busy || model_busy() || exp_q.size() != 0) && k < budget) begin step(); k++; end
      if (k >= budget) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: got busy after %0d cycles, expected idle", k);
      end
   endtask

   function automatic logic [79:0] log_rec(input int base);
      logic [79:0] r = '0;
      for (int i = 0; i < 10; i++)
         if (base + i < rx_log.size()) r = {r[71:0], rx_log[base+i]};
      return r;
   endfunction

   initial begin
      int k, run;
      trace_en = 1;
      do_reset();
      chk("reset_tx_valid", tx_valid, 1'b0);
      chk("reset_tx_data", tx_data, 8'h00);
      chk("reset_fifo_count", fifo_count, 0);

      // Register write, duplicate PC suppressed
      tx_ready = 1;
      reg_we = 1; reg_pc = 24'h000010; reg_sel = 4'd3; reg_data = 24'h8a4f1b; reg_op = 5'b10100;
      step(); step();
      drain(200);
      chk("reg_len", rx_log.size(), 10);
      chk("reg_record", log_rec(0), 80'h14_000010_000003_8a4f1b);
      chk("reg_drop", drop_cnt, 16'h0);

      // Store streams back-to-back, then a skipped store
      rx_log.delete();
      mem_valid = 1; mem_is_load = 0; mem_pc = 24'h20; mem_addr = 24'h000100;
      mem_wdata = 24'h123456; mem_op = 5'b10000;
      step(); idle_inputs();
      k = 0;
      while (!tx_valid && k < 10) begin step(); k++; end
      run = 0;
      while (tx_valid && run < 20) begin run++; step(); end
      chk("store_valid_run", run, 10);
      drain(200);
      chk("store_record", log_rec(0), 80'h50_000020_000100_123456);
      rx_log.delete();
      mem_valid = 1; mem_op = SKIP;
      step(); drain(200);
      chk("skip_no_record", rx_log.size(), 0);

      // Load with data one cycle later
      mem_valid = 1; mem_is_load = 1; mem_pc = 24'h30; mem_addr = 24'h200; mem_op = 5'b00011;
      step(); idle_inputs();
      mem_rdata = 24'hABCDEF;
      step(); mem_rdata = 24'h0;
      drain(200);
      chk("load_record", log_rec(0), 80'h83_000030_000200_abcdef);

      // Load, store and register pending together; stalled output toggling
      do_reset();
      tx_ready = 0;
      mem_valid = 1; mem_is_load = 1; mem_pc = 24'h50; mem_addr = 24'h300; mem_op = 5'b00010;
      step();
      mem_rdata = 24'h111111;
      mem_is_load = 0; mem_pc = 24'h54; mem_addr = 24'h304; mem_wdata = 24'h222222; mem_op = 5'b00100;
      reg_we = 1; reg_pc = 24'h58; reg_sel = 4'd5; reg_data = 24'h333333; reg_op = 5'b00110;
      step(); idle_inputs();
      k = 0;
      while ((busy || exp_q.size() != 0) && k < 200) begin tx_ready = ~tx_ready; step(); k++; end
      chk("order_len", rx_log.size(), 30);
      chk("order_load", log_rec(0), 80'h82_000050_000300_111111);
      chk("order_store", log_rec(10), 80'h44_000054_000304_222222);
      chk("order_reg", log_rec(20), 80'h06_000058_000005_333333);

      // Overflow with sink stalled
      do_reset();
      tx_ready = 0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         reg_we = 1; reg_pc = 24'h1000 + 24'(4 * i); reg_sel = 4'(i);
         reg_data = 24'($urandom); reg_op = 5'($urandom);
         step();
      end
      idle_inputs();
      chk("ovf_fifo_count", fifo_count, DEPTH);
      chk("ovf_drop_cnt", drop_cnt, 16'd1);
      tx_ready = 1;
      drain(500);
      chk("ovf_drained", rx_log.size(), 18 * 10);

      // Reset in the middle of a record
      do_reset();
      tx_ready = 1;
      mem_valid = 1; mem_is_load = 0; mem_pc = 24'h60; mem_addr = 24'h64; mem_wdata = 24'h5a5a5a; mem_op = 5'b00111;
      step(); idle_inputs();
      k = 0;
      while (rx_log.size() < 4 && k < 50) begin step(); k++; end
      chk("mid_bytes_seen", rx_log.size(), 4);
      rst = 1; step(); rst = 0;
      chk("mid_rst_tx_valid", tx_valid, 1'b0);
      chk("mid_rst_fifo_count", fifo_count, 0);
      chk("mid_rst_drop", drop_cnt, 16'h0);
      rx_log.delete();
      reg_we = 1; reg_pc = 24'h77; reg_sel = 4'd2; reg_data = 24'h00beef; reg_op = 5'b01010;
      step();
      drain(200);
      chk("post_rst_record", log_rec(0), 80'h0a_000077_000002_00beef);

      // Randomized traffic with varying sink throughput
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         trace_en    = ($urandom_range(0, 9) != 0);
         reg_we      = ($urandom_range(0, 2) == 0);
         reg_pc      = 24'(4 * $urandom_range(0, 7));
         reg_sel     = 4'($urandom);
         reg_data    = 24'($urandom);
         reg_op      = 5'($urandom);
         mem_valid   = ($urandom_range(0, 4) < 2);
         mem_is_load = 1'($urandom);
         mem_pc      = 24'($urandom);
         mem_addr    = 24'($urandom);
         mem_wdata   = 24'($urandom);
         mem_rdata   = 24'($urandom);
         mem_op      = 5'($urandom_range(0, 3));
         tx_ready    = ((c / 500) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) < 7);
         step();
      end
      trace_en = 1;
      tx_ready = 1;
      drain(2000);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
